// File: rtl/pc_pkg.sv
// ============================================================================
//  Module      : pc_pkg
//  Description : Shared opcode definitions for the PC sequencer and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        OP_SEQ  = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

endpackage

`default_nettype wire

// File: rtl/ras_stack.sv
// ============================================================================
//  Module      : ras_stack
//  Description : Return-address LIFO with full/empty status; no PC logic.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_stack #(
    parameter int AW        = 7,
    parameter int RAS_DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic [AW-1:0]                  data_i,
    output logic [AW-1:0]                  top_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0] depth_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int DW = $clog2(RAS_DEPTH + 1);
    localparam int IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [AW-1:0] mem_q [RAS_DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    assign full_o  = (depth_q == DW'(RAS_DEPTH));
    assign empty_o = (depth_q == '0);
    assign wr_idx  = IW'(depth_q);
    assign rd_idx  = IW'(depth_q - DW'(1));
    assign top_o   = mem_q[rd_idx];
    assign depth_o = depth_q;

    // Push when full and pop when empty are ignored so entries are preserved.
    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter sequencer with wrap, jump and call/return.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int AW        = 7,
    parameter int PC_MAX    = 2**AW - 1,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_PC  = 0
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           En,
    input  logic [OP_W-1:0]                Op,
    input  logic [AW-1:0]                  Target,
    input  logic                           ClrFlags,
    output logic [AW-1:0]                  PC,
    output logic [$clog2(RAS_DEPTH+1)-1:0] Depth,
    output logic                           Wrapped,
    output logic                           Overflow,
    output logic                           Underflow,
    output logic                           BadTarget
);

    localparam logic [AW-1:0] c_pc_max   = AW'(PC_MAX);
    localparam logic [AW-1:0] c_reset_pc = AW'(RESET_PC);

    op_e           op;
    logic [AW-1:0] pc_q, pc_d;
    logic          wrapped_q, wrapped_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          bad_q, bad_d;
    logic          at_max;
    logic [AW-1:0] nxt;
    logic          tgt_bad;
    logic          push, pop;
    logic [AW-1:0] stk_top;
    logic          stk_full, stk_empty;

    assign op      = op_e'(Op);
    assign at_max  = (pc_q == c_pc_max);
    assign nxt     = at_max ? '0 : pc_q + AW'(1);
    assign tgt_bad = (Target > c_pc_max);

    ras_stack #(
        .AW        (AW),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (nxt),
        .top_o   (stk_top),
        .depth_o (Depth),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    // Clears are applied before the op so that a set in the same cycle wins.
    always_comb begin
        pc_d      = pc_q;
        wrapped_d = 1'b0;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        bad_d     = bad_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (En) begin
            if (ClrFlags) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                bad_d = 1'b0;
            end
            case (op)
                OP_SEQ: begin
                    pc_d      = nxt;
                    wrapped_d = at_max;
                end
                OP_JUMP, OP_CALL: begin
                    pc_d = tgt_bad ? '0 : Target;
                    if (tgt_bad) begin
                        bad_d = 1'b1;
                    end
                    if (op == OP_CALL) begin
                        if (stk_full) begin
                            ovf_d = 1'b1;
                        end else begin
                            push = 1'b1;
                        end
                    end
                end
                OP_RET: begin
                    if (stk_empty) begin
                        unf_d     = 1'b1;
                        pc_d      = nxt;
                        wrapped_d = at_max;
                    end else begin
                        pop  = 1'b1;
                        pc_d = stk_top;
                    end
                end
                default: begin
                    pc_d = pc_q;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q      <= c_reset_pc;
            wrapped_q <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            bad_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            wrapped_q <= wrapped_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            bad_q     <= bad_d;
        end
    end

    assign PC        = pc_q;
    assign Wrapped   = wrapped_q;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
    assign BadTarget = bad_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed plus randomized bench with a queue-based PC model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    localparam int AW     = 7;
    localparam int PCMAX  = 31;
    localparam int DEPTH  = 4;

    localparam logic [1:0] SEQ  = 2'b00;
    localparam logic [1:0] JUMP = 2'b01;
    localparam logic [1:0] CALL = 2'b10;
    localparam logic [1:0] RET  = 2'b11;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          En;
    logic [1:0]    Op;
    logic [AW-1:0] Target;
    logic          ClrFlags;
    logic [AW-1:0] PC;
    logic [2:0]    Depth;
    logic          Wrapped, Overflow, Underflow, BadTarget;

    int checks = 0;
    int errors = 0;

    // Reference state
    int   m_pc;
    int   m_stk[$];
    logic m_wr, m_ovf, m_unf, m_bad;

    pc_sequencer #(
        .AW        (AW),
        .PC_MAX    (PCMAX),
        .RAS_DEPTH (DEPTH),
        .RESET_PC  (0)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .En        (En),
        .Op        (Op),
        .Target    (Target),
        .ClrFlags  (ClrFlags),
        .PC        (PC),
        .Depth     (Depth),
        .Wrapped   (Wrapped),
        .Overflow  (Overflow),
        .Underflow (Underflow),
        .BadTarget (BadTarget)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".PC"},        {25'd0, PC},        m_pc);
        chk({tag, ".Depth"},     {29'd0, Depth},     m_stk.size());
        chk({tag, ".Wrapped"},   {31'd0, Wrapped},   {31'd0, m_wr});
        chk({tag, ".Overflow"},  {31'd0, Overflow},  {31'd0, m_ovf});
        chk({tag, ".Underflow"}, {31'd0, Underflow}, {31'd0, m_unf});
        chk({tag, ".BadTarget"}, {31'd0, BadTarget}, {31'd0, m_bad});
    endtask

    task automatic model_reset();
        m_pc = 0;
        m_stk.delete();
        m_wr = 0; m_ovf = 0; m_unf = 0; m_bad = 0;
    endtask

    task automatic do_jump(input int tgt);
        if (tgt > PCMAX) begin
            m_pc  = 0;
            m_bad = 1;
        end else begin
            m_pc = tgt;
        end
    endtask

    task automatic step(input string tag, input logic en, input logic [1:0] op,
                        input int tgt, input logic clr);
        int nxt;
        En = en; Op = op; Target = AW'(tgt); ClrFlags = clr;
        @(posedge Clk);
        m_wr = 0;
        if (en) begin
            nxt = (m_pc == PCMAX) ? 0 : m_pc + 1;
            if (clr) begin
                m_ovf = 0; m_unf = 0; m_bad = 0;
            end
            case (op)
                SEQ: begin
                    m_wr = (m_pc == PCMAX);
                    m_pc = nxt;
                end
                JUMP: do_jump(tgt);
                CALL: begin
                    if (m_stk.size() == DEPTH) m_ovf = 1;
                    else m_stk.push_back(nxt);
                    do_jump(tgt);
                end
                default: begin
                    if (m_stk.size() > 0) begin
                        m_pc = m_stk.pop_back();
                    end else begin
                        m_unf = 1;
                        m_wr  = (m_pc == PCMAX);
                        m_pc  = nxt;
                    end
                end
            endcase
        end
        #1;
        chk_all(tag);
    endtask

    initial begin
        Reset = 1'b1; En = 1'b0; Op = SEQ; Target = '0; ClrFlags = 1'b0;
        model_reset();
        #1;
        chk_all("reset");
        #1 Reset = 1'b0;

        // Count through the wrap
        for (int i = 0; i < 33; i++) step("seq_wrap", 1'b1, SEQ, 0, 1'b0);

        // Async reset between edges
        for (int i = 0; i < 5; i++) step("seq_pre_rst", 1'b1, SEQ, 0, 1'b0);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        Reset = 1'b0;
        step("post_rst", 1'b1, SEQ, 0, 1'b0);

        // Stall and jump
        step("jump20", 1'b1, JUMP, 20, 1'b0);
        for (int i = 0; i < 3; i++) step("stall", 1'b0, CALL, 9, 1'b0);
        step("after_stall", 1'b1, SEQ, 0, 1'b0);

        // Nested calls
        step("jump5", 1'b1, JUMP, 5, 1'b0);
        step("call10", 1'b1, CALL, 10, 1'b0);
        step("call15", 1'b1, CALL, 15, 1'b0);
        step("ret1", 1'b1, RET, 0, 1'b0);
        step("ret2", 1'b1, RET, 0, 1'b0);

        // Overflow then LIFO unwind
        for (int i = 0; i < 5; i++) step("ovf_call", 1'b1, CALL, 3 + 4 * i, 1'b0);
        for (int i = 0; i < 4; i++) step("ovf_ret", 1'b1, RET, 0, 1'b0);
        step("clr_ovf", 1'b1, SEQ, 0, 1'b1);

        // Underflow with wrap, then clear behaviour
        step("jump31", 1'b1, JUMP, 31, 1'b0);
        step("unf_ret", 1'b1, RET, 0, 1'b0);
        step("clr_only", 1'b1, SEQ, 0, 1'b1);
        step("clr_vs_set", 1'b1, RET, 0, 1'b1);

        // Bad target
        step("bad_jump", 1'b1, JUMP, 40, 1'b0);
        step("bad_call", 1'b1, CALL, 45, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)),
                 int'($urandom_range(0, 40)),
                 ($urandom_range(0, 9) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer: the next generation of the core's program counter. It produces the instruction address each cycle and supports sequential increment with a configurable wrap limit, stall, absolute jump, and call/return through an internal return-address stack with overflow and underflow detection. It sits between the control unit, which drives `Op`, `Target` and `En`, and instruction memory, which consumes `PC`.

## Interface
- `AW`, default 7: address width in bits.
- `PC_MAX`, default 2**AW-1: highest legal address; a sequential step from `PC_MAX` wraps to 0. Legal range is 1..2**AW-1.
- `RAS_DEPTH`, default 4: return-address stack entries; must be ≥1.
- `RESET_PC`, default 0: value of `PC` after reset; must be ≤ `PC_MAX`.

Ports:
- `Clk`  in  1: clock; all state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `En`  in  1: advance enable; 0 stalls (all state holds).
- `Op`  in  2: 00 SEQ, 01 JUMP, 10 CALL, 11 RET.
- `Target`  in  AW: destination address for JUMP and CALL.
- `ClrFlags`  in  1: synchronous clear of the sticky flags.
- `PC`  out  AW: current instruction address (registered).
- `Depth`  out  $clog2(RAS_DEPTH+1): number of valid stack entries.
- `Wrapped`  out  1: one-cycle pulse; PC reached 0 through a sequential wrap.
- `Overflow`  out  1: sticky; a CALL was issued with the stack full.
- `Underflow`  out  1: sticky; a RET was issued with the stack empty.
- `BadTarget`  out  1: sticky; a JUMP or CALL was issued with `Target` > `PC_MAX`.

## Operation
- **Reset:** `PC`=`RESET_PC`, `Depth`=0, `Wrapped`=0, and all sticky flags 0. Stack contents are don't-care.
- **Next sequential address:** nxt = (`PC`==`PC_MAX`) ? 0 : `PC`+1. The add is AW bits wide and never exceeds `PC_MAX`.
- **En=0:** `PC`, stack and `Depth` hold; `Wrapped`=0. `Op`, `Target` and `ClrFlags` are ignored.
- **En=1, SEQ:** `PC` <= nxt. `Wrapped` <= 1 if and only if `PC`==`PC_MAX`.
- **En=1, JUMP:** `PC` <= `Target`.
  - If `Target` > `PC_MAX`: `PC` <= 0 and `BadTarget` is set.
- **En=1, CALL:** push nxt, then `PC` <= `Target`, with the same `BadTarget` rule as JUMP.
  - If `Depth`==`RAS_DEPTH`: no push, existing entries are preserved, `Overflow` is set, and the jump still occurs.
- **En=1, RET:** if `Depth`>0, pop and `PC` <= popped entry.
  - If `Depth`==0: `Underflow` is set and `PC` <= nxt. `Wrapped` applies as for SEQ.
- **Flags:** `ClrFlags`=1 with `En`=1 clears all sticky flags. If a flag is set and cleared in the same cycle, set wins.
- **Stack:** LIFO. The stack top is always the most recent unpopped CALL.

## Timing
- Latency is 1 cycle: `Op` sampled at edge n is reflected in `PC` and `Depth` after edge n.
- `Wrapped` is registered and asserted in the same cycle that `PC` shows 0.
- Back-to-back CALL→RET is supported without bubbles: a RET on the cycle after a CALL returns the address pushed by that CALL.
- A RET immediately after reset underflows.
- `Reset` asserted mid-operation forces reset values immediately, without waiting for a clock edge. Normal operation resumes at the first rising edge after deassertion.
- There are no combinational paths from inputs to outputs.

## Structure
- **Shared package `pc_pkg`:** the `Op` enum (`OP_SEQ`, `OP_JUMP`, `OP_CALL`, `OP_RET`) and the 2-bit op width constant. The ALU/control decoder imports the same package.
- **Sub-module `ras_stack`:** parametrised by AW and `RAS_DEPTH`. It provides push/pop/top/`Depth`/full/empty and contains no PC logic.
- **`pc_sequencer`:** the next-PC mux, wrap detect, flags, and the `ras_stack` instance.

## Test plan
- **Reset and wrap:** AW=7, `PC_MAX`=31, SEQ for 33 cycles → `PC` counts 0..31, then 0. `Wrapped` is high exactly in the cycle `PC`=0 after 31. An async `Reset` pulse mid-count gives `PC`=0 immediately.
- **Stall and jump:** JUMP `Target`=20, then `En`=0 for 3 cycles with `Op`=CALL → `PC` holds 20 and `Depth` stays 0. Next SEQ → 21.
- **Nested calls:** `PC`=5, CALL 10; at 10, CALL 15; at 15, RET; then RET → `PC` sequence 5, 10, 15, 11, 6 and `Depth` sequence 0, 1, 2, 1, 0.
- **Overflow:** `RAS_DEPTH`=4, five consecutive CALLs → `Depth`=4 and `Overflow`=1. Four RETs return the first four return addresses in LIFO order.
- **Underflow and flag clear:** RET at `PC`=31 with `PC_MAX`=31 → `PC`=0, `Underflow`=1, `Wrapped`=1. `ClrFlags` alone → `Underflow`=0. `ClrFlags` with a RET while empty → `Underflow` stays 1.
- **Bad target:** `PC_MAX`=31, JUMP `Target`=40 → `PC`=0 and `BadTarget`=1.
